clock_mode_sequencer: RTL and testbench

Front-end controller for the digital clock's time-setting path.
- Turns two raw pushbuttons (MODE, ADVANCE) into the active-low set / set_h / set_m controls consumed by clock_control.
- Steps the clock through RUN → SET_HOURS → SET_MINUTES → RUN, and drops back to RUN automatically after an idle period.
- Also drives a blink flag so the display can flash the field being edited.

---
 rtl/clock_mode_sequencer.sv | 137 +++++++++++++
 tb/tb_clock_mode_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_sequencer.sv
// Time-setting front end: debounces MODE/ADVANCE, sequences RUN -> SET_H -> SET_M,
// and drives the active-low set controls plus a blink strobe for the edited field.
module clock_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_S       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_adv,
  output logic       set,
  output logic       set_h,
  output logic       set_m,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_S - 1);

  // Bit 0 carries MODE, bit 1 carries ADVANCE through the whole front end.
  logic [1:0]  w_raw;
  logic [1:0]  r_s1;
  logic [1:0]  r_s2;
  logic [1:0]  r_stable;
  logic [1:0]  r_stable_d;
  logic [1:0]  r_press;
  logic [15:0] r_db_cnt [2];

  assign w_raw = {btn_adv, btn_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
      for (int unsigned i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  logic w_press_mode;
  logic w_press_adv;
  logic w_adv_stable;

  assign w_press_mode = r_press[0];
  assign w_press_adv  = r_press[1];
  assign w_adv_stable = r_stable[1];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_idle;
  logic [7:0] w_idle_nxt;
  logic       r_blink;
  logic       w_blink_nxt;
  logic       r_set;
  logic       r_set_h;
  logic       r_set_m;
  logic       w_set_nxt;
  logic       w_set_h_nxt;
  logic       w_set_m_nxt;
  logic       w_timeout;
  logic       w_entry;

  always_comb begin
    w_state_nxt = ST_RUN;
    // A tick seen while ADVANCE is held is activity, not idle time.
    w_timeout   = (r_state != ST_RUN) && !w_adv_stable && tick_1hz && (r_idle == TO_LAST);
    case (r_state)
      ST_RUN:   w_state_nxt = w_press_mode ? ST_SET_H : ST_RUN;
      ST_SET_H: w_state_nxt = w_press_mode ? ST_SET_M : (w_timeout ? ST_RUN : ST_SET_H);
      ST_SET_M: w_state_nxt = (w_press_mode || w_timeout) ? ST_RUN : ST_SET_M;
      default:  w_state_nxt = ST_RUN;
    endcase
    w_entry = (w_state_nxt != r_state);

    w_idle_nxt = r_idle;
    if (w_entry || w_press_mode || w_press_adv || w_adv_stable) w_idle_nxt = '0;
    else if (tick_1hz && (r_idle != '1))                        w_idle_nxt = r_idle + 8'd1;

    w_blink_nxt = r_blink;
    if ((w_state_nxt == ST_RUN) || w_entry || w_adv_stable) w_blink_nxt = 1'b0;
    else if (tick_1hz)                                       w_blink_nxt = ~r_blink;

    w_set_nxt   = (w_state_nxt == ST_RUN);
    w_set_h_nxt = !((w_state_nxt == ST_SET_H) && w_adv_stable);
    w_set_m_nxt = !((w_state_nxt == ST_SET_M) && w_adv_stable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_idle  <= '0;
      r_blink <= 1'b0;
      r_set   <= 1'b1;
      r_set_h <= 1'b1;
      r_set_m <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_blink <= w_blink_nxt;
      r_set   <= w_set_nxt;
      r_set_h <= w_set_h_nxt;
      r_set_m <= w_set_m_nxt;
    end
  end

  assign mode  = r_state;
  assign set   = r_set;
  assign set_h = r_set_h;
  assign set_m = r_set_m;
  assign blink = r_blink;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Bench for clock_mode_sequencer: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the button/mode rules.
module tb_clock_mode_sequencer;

  localparam int D  = 4;
  localparam int T  = 3;
  localparam int TP = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_adv;
  logic       set;
  logic       set_h;
  logic       set_m;
  logic [1:0] mode;
  logic       blink;

  always #5 clk = ~clk;

  clock_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_S      (T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_adv (btn_adv),
    .set     (set),
    .set_h   (set_h),
    .set_m   (set_m),
    .mode    (mode),
    .blink   (blink)
  );

  int total = 0;
  int bad   = 0;
  int tph   = 0;
  int ticks_seen = 0;

  // Model: raw sample history per button (bit 0 newest), debounced levels,
  // press pulses, mode number, idle ticks and ticks since blink restart.
  logic [15:0] hm, ha;
  bit          st_m, st_a, pv_m, pv_a, pr_m, pr_a;
  int          m_state, m_idle, m_bt;
  logic [5:0]  e_vec;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit nst_m, nst_a, to;
    int nxt;
    if (rst) begin
      hm = '0; ha = '0;
      st_m = 0; st_a = 0; pv_m = 0; pv_a = 0; pr_m = 0; pr_a = 0;
      m_state = 0; m_idle = 0; m_bt = 0;
      e_vec = 6'b00_111_0;
    end else begin
      // A level is accepted after D consecutive synchronized samples disagree with it.
      nst_m = (hm[D:1] == {D{~st_m}}) ? ~st_m : st_m;
      nst_a = (ha[D:1] == {D{~st_a}}) ? ~st_a : st_a;
      to = (m_state != 0) && !st_a && (tick_1hz == 1'b1) && (m_idle == T - 1);
      case (m_state)
        0:       nxt = pr_m ? 1 : 0;
        1:       nxt = pr_m ? 2 : (to ? 0 : 1);
        2:       nxt = (pr_m || to) ? 0 : 2;
        default: nxt = 0;
      endcase
      if (nxt != m_state || pr_m || pr_a || st_a) m_idle = 0;
      else if (tick_1hz && m_idle < 255)          m_idle++;
      if (nxt == 0 || nxt != m_state || st_a) m_bt = 0;
      else if (tick_1hz)                      m_bt++;
      e_vec = {2'(nxt), nxt == 0, !(nxt == 1 && st_a), !(nxt == 2 && st_a), m_bt[0]};
      hm = {hm[14:0], btn_mode};
      ha = {ha[14:0], btn_adv};
      pr_m = st_m & ~pv_m;  pv_m = st_m;  st_m = nst_m;
      pr_a = st_a & ~pv_a;  pv_a = st_a;  st_a = nst_a;
      m_state = nxt;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    if (tick_1hz) ticks_seen++;
    check("outs", {2'b00, mode, set, set_h, set_m, blink}, {2'b00, e_vec});
    tph      = (tph + 1) % TP;
    tick_1hz = (tph == TP - 1);
  endtask

  task automatic press(input int hold);
    btn_mode = 1'b1;
    repeat (hold) cyc();
    btn_mode = 1'b0;
    repeat (8) cyc();
  endtask

  // Raise MODE so its press pulse lands on the third idle tick.
  task automatic aligned_press(input logic [1:0] want);
    int ts;
    ts = ticks_seen;
    while (ticks_seen - ts < 2) cyc();
    while (tph != 42) cyc();
    btn_mode = 1'b1;
    repeat (8) cyc();
    check("align_mode", mode, want);
    btn_mode = 1'b0;
    repeat (10) cyc();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_adv = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    repeat (200) cyc();
    check("idle_mode", mode, 0);
    check("idle_sets", {set, set_h, set_m}, 3'b111);
    check("idle_blink", blink, 0);

    press(3);
    repeat (10) cyc();
    press(2);
    repeat (10) cyc();
    check("glitch_mode", mode, 0);

    btn_mode = 1'b1;
    repeat (7) cyc();
    check("lat_before", mode, 0);
    cyc();
    check("lat_mode", mode, 1);
    check("lat_sets", {set, set_h}, 2'b01);
    repeat (2) cyc();
    btn_mode = 1'b0;

    btn_adv = 1'b1;
    repeat (60) cyc();
    check("advh_set_h", set_h, 0);
    check("advh_blink", blink, 0);
    repeat (60) cyc();
    check("advh_mode", mode, 1);
    btn_adv = 1'b0;
    repeat (220) cyc();
    check("timeout_mode", mode, 0);
    check("timeout_sets", {set, set_h, set_m}, 3'b111);

    press(8);
    press(8);
    check("two_press", mode, 2);
    btn_adv = 1'b1;
    repeat (30) cyc();
    check("advm_sets", {set_h, set_m}, 2'b10);
    btn_mode = 1'b1;
    repeat (7) cyc();
    check("advm_hold", mode, 2);
    cyc();
    check("advm_exit", {mode, set_m}, 3'b001);
    btn_mode = 1'b0; btn_adv = 1'b0;
    repeat (20) cyc();

    while (tph != 0) cyc();
    press(8);
    press(8);
    aligned_press(2'b00);
    while (tph != 0) cyc();
    press(8);
    aligned_press(2'b10);
    repeat (220) cyc();
    check("back_run", mode, 0);

    press(8);
    btn_adv = 1'b1;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mode", mode, 0);
    check("rst_outs", {set, set_h, set_m, blink}, 4'b1110);
    repeat (30) cyc();
    check("rst_adv_ign", mode, 0);
    btn_adv = 1'b0;
    repeat (20) cyc();

    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 7))
        0, 5: repeat ($urandom_range(1, 80)) cyc();
        1: begin
          btn_mode = 1'b1;
          repeat ($urandom_range(1, 10)) cyc();
          btn_mode = 1'b0;
          repeat ($urandom_range(1, 12)) cyc();
        end
        2: begin
          btn_adv = 1'b1;
          repeat ($urandom_range(1, 150)) cyc();
          btn_adv = 1'b0;
          repeat ($urandom_range(1, 12)) cyc();
        end
        3, 6: begin
          btn_adv = 1'b1;
          btn_mode = 1'b1;
          repeat ($urandom_range(1, 10)) cyc();
          btn_mode = 1'b0;
          repeat ($urandom_range(1, 40)) cyc();
          btn_adv = 1'b0;
          repeat ($urandom_range(1, 12)) cyc();
        end
        4: begin
          repeat ($urandom_range(1, 20)) begin
            btn_mode = 1'($urandom_range(0, 1));
            btn_adv  = 1'($urandom_range(0, 1));
            cyc();
          end
          btn_mode = 1'b0; btn_adv = 1'b0;
        end
        default: begin
          rst = 1'b1;
          cyc();
          rst = 1'b0;
        end
      endcase
    end
    repeat (20) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
